stream_delay: RTL and testbench



---
 rtl/stream_delay_pkg.sv | 13 +
 rtl/stream_delay_lfsr_16.sv | 28 ++
 rtl/stream_delay.sv | 132 +++++++++++++
 tb/tb_stream_delay.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/stream_delay_pkg.sv
// Shared constants and the LFSR step function for the stream delay stage.
package stream_delay_pkg;

    localparam int unsigned LFSR_W = 16;

    // Fibonacci step with taps 16,14,13,11, which is maximal length, so a non-zero seed never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

endpackage

// File: rtl/stream_delay_lfsr_16.sv
// Seeded 16-bit Fibonacci LFSR with enable and synchronous reset.
module lfsr_16
    import stream_delay_pkg::*;
#(
    parameter logic [LFSR_W-1:0] Seed = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_r;

    // Shift register: reload the seed on reset, step when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= Seed;
        end else if (en_i) begin
            state_r <= lfsr_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state_o = state_r;

endmodule

// File: rtl/stream_delay.sv
// Valid/ready stage that holds back each transaction for a fixed or LFSR-drawn delay.
// Only the handshake is gated; the payload wire passes straight through.
module stream_delay
    import stream_delay_pkg::*;
#(
    parameter type         payload_t   = logic,
    parameter bit          StallRandom = 1'b0,
    parameter int unsigned FixedDelay  = 1,
    parameter int unsigned RandWidth   = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  payload_t payload_i,
    input  logic     valid_i,
    output logic     ready_o,
    output payload_t payload_o,
    output logic     valid_o,
    input  logic     ready_i
);

    localparam int unsigned FIX_W = (FixedDelay < 2) ? 1 : $clog2(FixedDelay + 1);
    localparam int unsigned CNT_W = StallRandom ? RandWidth : FIX_W;

    assign payload_o = payload_i;

    if (!StallRandom && (FixedDelay == 0)) begin : g_pass
        assign valid_o = valid_i;
        assign ready_o = ready_i;

        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
    end else begin : g_delay
        typedef enum logic [1:0] {
            IDLE  = 2'd0,
            COUNT = 2'd1,
            READY = 2'd2
        } state_e;

        state_e             state_r;
        state_e             state_next_s;
        logic [CNT_W-1:0]   cnt_r;
        logic [CNT_W-1:0]   cnt_next_s;
        logic [CNT_W-1:0]   d_s;

        if (StallRandom) begin : g_rand
            logic [LFSR_W-1:0] lfsr_s;
            logic              unused_lfsr;

            lfsr_16 #(
                .Seed(LfsrSeed)
            ) u_lfsr (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .en_i   (1'b1),
                .state_o(lfsr_s)
            );

            // Delay is the low bits of the LFSR in the cycle the beat is first seen.
            assign d_s         = lfsr_s[RandWidth-1:0];
            assign unused_lfsr = ^lfsr_s;
        end else begin : g_fix
            assign d_s = CNT_W'(FixedDelay);
        end

        // State and countdown registers.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_r <= IDLE;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                state_r <= state_next_s;
                cnt_r   <= cnt_next_s;
            end
        end

        // Next-state and handshake gating.
        always_comb begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
            valid_o      = 1'b0;
            ready_o      = 1'b0;
            if (rst_i) begin
                state_next_s = IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (!valid_i) begin
                            state_next_s = IDLE;
                        end else if (d_s == {CNT_W{1'b0}}) begin
                            valid_o = valid_i;
                            ready_o = ready_i;
                            if (ready_i) begin
                                state_next_s = IDLE;
                            end else begin
                                state_next_s = READY;
                            end
                        end else if (d_s == CNT_W'(1)) begin
                            state_next_s = READY;
                        end else begin
                            cnt_next_s   = d_s - CNT_W'(1);
                            state_next_s = COUNT;
                        end
                    end
                    COUNT: begin
                        // An upstream that withdraws valid forfeits the remaining delay.
                        if (!valid_i) begin
                            state_next_s = IDLE;
                        end else if (cnt_r == CNT_W'(1)) begin
                            state_next_s = READY;
                        end else begin
                            cnt_next_s = cnt_r - CNT_W'(1);
                        end
                    end
                    READY: begin
                        valid_o = valid_i;
                        ready_o = ready_i;
                        if (!valid_i || ready_i) begin
                            state_next_s = IDLE;
                        end else begin
                            state_next_s = READY;
                        end
                    end
                    default: begin
                        state_next_s = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_delay.sv
// Directed bench for stream_delay: pass-through, fixed delays, reset, abandon, and random delays.
module tb_stream_delay;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] p_p, p_f1, p_f2, p_f3, p_rn;
    logic [7:0] po_p, po_f1, po_f2, po_f3, po_rn;
    logic v_p = 1'b0, v_f1 = 1'b0, v_f2 = 1'b0, v_f3 = 1'b0, v_rn = 1'b0;
    logic r_p = 1'b0, r_f1 = 1'b0, r_f2 = 1'b0, r_f3 = 1'b0, r_rn = 1'b0;
    logic vo_p, vo_f1, vo_f2, vo_f3, vo_rn;
    logic ro_p, ro_f1, ro_f2, ro_f3, ro_rn;

    stream_delay #(.payload_t(logic [7:0]), .StallRandom(1'b0), .FixedDelay(0)) u_pass (
        .clk_i(clk), .rst_i(rst), .payload_i(p_p), .valid_i(v_p), .ready_o(ro_p),
        .payload_o(po_p), .valid_o(vo_p), .ready_i(r_p));
    stream_delay #(.payload_t(logic [7:0]), .StallRandom(1'b0), .FixedDelay(1)) u_f1 (
        .clk_i(clk), .rst_i(rst), .payload_i(p_f1), .valid_i(v_f1), .ready_o(ro_f1),
        .payload_o(po_f1), .valid_o(vo_f1), .ready_i(r_f1));
    stream_delay #(.payload_t(logic [7:0]), .StallRandom(1'b0), .FixedDelay(2)) u_f2 (
        .clk_i(clk), .rst_i(rst), .payload_i(p_f2), .valid_i(v_f2), .ready_o(ro_f2),
        .payload_o(po_f2), .valid_o(vo_f2), .ready_i(r_f2));
    stream_delay #(.payload_t(logic [7:0]), .StallRandom(1'b0), .FixedDelay(3)) u_f3 (
        .clk_i(clk), .rst_i(rst), .payload_i(p_f3), .valid_i(v_f3), .ready_o(ro_f3),
        .payload_o(po_f3), .valid_o(vo_f3), .ready_i(r_f3));
    stream_delay #(.payload_t(logic [7:0]), .StallRandom(1'b1), .RandWidth(4)) u_rnd (
        .clk_i(clk), .rst_i(rst), .payload_i(p_rn), .valid_i(v_rn), .ready_o(ro_rn),
        .payload_o(po_rn), .valid_o(vo_rn), .ready_i(r_rn));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] hist;
    int          nbeats;
    int          ndist;
    int          cyc;
    bit          seen;
    bit          done;

    initial begin
        p_p = 8'h00; p_f1 = 8'h00; p_f2 = 8'h00; p_f3 = 8'h00; p_rn = 8'h00;

        // Reset state: beat offered during reset is not passed
        next_cycle();
        v_f3 = 1'b1; r_f3 = 1'b1;
        @(negedge clk);
        check_eq("rst_valid_o", 32'(vo_f3), 32'd0);
        check_eq("rst_ready_o", 32'(ro_f3), 32'd0);
        next_cycle();
        v_f3 = 1'b0; r_f3 = 1'b0; rst = 1'b0;
        next_cycle();

        // Pass-through: four beats in four cycles
        for (int c = 0; c < 4; c++) begin
            v_p = 1'b1; r_p = 1'b1; p_p = 8'hA0 + 8'(c);
            @(negedge clk);
            check_eq("pass_valid", 32'(vo_p), 32'd1);
            check_eq("pass_ready", 32'(ro_p), 32'd1);
            check_eq("pass_payload", 32'(po_p), 32'(8'hA0 + 8'(c)));
            next_cycle();
        end
        v_p = 1'b0; r_p = 1'b0;

        // FixedDelay=1: valid at cycles 1 and 3
        v_f1 = 1'b1; r_f1 = 1'b1; p_f1 = 8'h11;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) p_f1 = 8'h22;
            @(negedge clk);
            check_eq("f1_valid", 32'(vo_f1), (c == 1 || c == 3) ? 32'd1 : 32'd0);
            check_eq("f1_ready", 32'(ro_f1), (c == 1 || c == 3) ? 32'd1 : 32'd0);
            if (c == 3) check_eq("f1_payload", 32'(po_f1), 32'h22);
            next_cycle();
        end
        v_f1 = 1'b0; r_f1 = 1'b0;
        next_cycle();

        // FixedDelay=3 with back-pressure to cycle 6, then a second beat from cycle 7
        v_f3 = 1'b1; p_f3 = 8'h33;
        for (int c = 0; c <= 10; c++) begin
            r_f3 = (c >= 6);
            @(negedge clk);
            check_eq("f3_valid", 32'(vo_f3), ((c >= 3 && c <= 6) || c == 10) ? 32'd1 : 32'd0);
            check_eq("f3_ready", 32'(ro_f3), (c == 6 || c == 10) ? 32'd1 : 32'd0);
            next_cycle();
        end
        v_f3 = 1'b0; r_f3 = 1'b0;
        next_cycle();

        // FixedDelay=3 with a reset pulse in cycle 1
        v_f3 = 1'b1; r_f3 = 1'b1; p_f3 = 8'h44;
        for (int c = 0; c <= 5; c++) begin
            rst = (c == 1);
            @(negedge clk);
            check_eq("f3rst_valid", 32'(vo_f3), (c == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        rst = 1'b0; v_f3 = 1'b0; r_f3 = 1'b0;
        next_cycle();

        // FixedDelay=2: valid drops in COUNT, new beat at cycle 2 appears at cycle 4
        r_f2 = 1'b1; p_f2 = 8'h55;
        for (int c = 0; c <= 4; c++) begin
            v_f2 = (c != 1);
            @(negedge clk);
            check_eq("f2_abandon_valid", 32'(vo_f2), (c == 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        v_f2 = 1'b0; r_f2 = 1'b0;
        next_cycle();

        // Random delays with random back-pressure
        hist = 16'h0000;
        nbeats = 0;
        for (int i = 0; i < 200; i++) begin
            p_rn = i[7:0]; v_rn = 1'b1;
            seen = 1'b0; done = 1'b0; cyc = 0;
            while (!done) begin
                r_rn = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (vo_rn && !seen) begin
                    seen = 1'b1;
                    check_eq("rnd_delay_range", 32'(cyc <= 15), 32'd1);
                    if (cyc <= 15) hist[cyc] = 1'b1;
                end
                if (vo_rn && r_rn) begin
                    check_eq("rnd_payload", 32'(po_rn), 32'(i[7:0]));
                    check_eq("rnd_ready", 32'(ro_rn), 32'd1);
                    nbeats++;
                    done = 1'b1;
                end else if (cyc >= 60) begin
                    check_eq("rnd_timeout", 32'(cyc), 32'd0);
                    done = 1'b1;
                end
                next_cycle();
                cyc++;
            end
        end
        v_rn = 1'b0; r_rn = 1'b0;
        ndist = 0;
        for (int k = 0; k < 16; k++) ndist += int'(hist[k]);
        check_eq("rnd_beats", 32'(nbeats), 32'd200);
        check_eq("rnd_distinct_ge8", 32'(ndist >= 8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
